// File: rtl/ifetch_data_stage_pkg.sv
// Shared widths, bus layout and helpers for the instruction-fetch data stage.
package ifetch_data_stage_pkg;

    localparam int unsigned NUM_WARP_PER_CORE         = 4;
    localparam int unsigned NUM_WARP_PER_CORE_LOG     = $clog2(NUM_WARP_PER_CORE);
    localparam int unsigned ADDR_WIDTH                = 32;
    localparam int unsigned L1_CACHE_NUM_WAYS         = 4;
    localparam int unsigned L1_CACHE_NUM_WAYS_LOG     = $clog2(L1_CACHE_NUM_WAYS);
    localparam int unsigned L1_CACHE_NUM_SETS         = 64;
    localparam int unsigned L1_CACHE_NUM_SETS_LOG     = $clog2(L1_CACHE_NUM_SETS);
    localparam int unsigned CACHE_LINE_BYTE_WIDTH     = 64;
    localparam int unsigned CACHE_LINE_BYTE_WIDTH_LOG = $clog2(CACHE_LINE_BYTE_WIDTH);
    localparam int unsigned TAG_WIDTH =
        ADDR_WIDTH - L1_CACHE_NUM_SETS_LOG - CACHE_LINE_BYTE_WIDTH_LOG;

    localparam int unsigned IFT_TO_IFD_BUS_WIDTH = ADDR_WIDTH + NUM_WARP_PER_CORE_LOG;
    localparam int unsigned IFD_TO_ID_BUS_WIDTH  = ADDR_WIDTH + NUM_WARP_PER_CORE_LOG;

    // {pc, warp_idx}: warp index in the LSBs
    localparam int unsigned BUS_WARP_LSB = 0;
    localparam int unsigned BUS_PC_LSB   = NUM_WARP_PER_CORE_LOG;

    function automatic logic [L1_CACHE_NUM_WAYS_LOG-1:0] oh_to_idx(
        input logic [L1_CACHE_NUM_WAYS-1:0] oh
    );
        logic [L1_CACHE_NUM_WAYS_LOG-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < L1_CACHE_NUM_WAYS; i++) begin
            if (oh[i]) idx = idx | L1_CACHE_NUM_WAYS_LOG'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ifetch_data_stage_tag_compare.sv
// Combinational icache tag match across all ways of one set.
module icache_tag_compare
    import ifetch_data_stage_pkg::*;
(
    input  logic [L1_CACHE_NUM_WAYS-1:0]           tag_valid,
    input  logic [L1_CACHE_NUM_WAYS*TAG_WIDTH-1:0] tags,
    input  logic [TAG_WIDTH-1:0]                   lookup_tag,
    output logic                                   hit,
    output logic [L1_CACHE_NUM_WAYS-1:0]           hit_oh,
    output logic [L1_CACHE_NUM_WAYS_LOG-1:0]       hit_way
);

    always_comb begin
        hit_oh = '0;
        for (int unsigned w = 0; w < L1_CACHE_NUM_WAYS; w++) begin
            hit_oh[w] = tag_valid[w] & (tags[w*TAG_WIDTH +: TAG_WIDTH] == lookup_tag);
        end
    end

    assign hit     = |hit_oh;
    assign hit_way = oh_to_idx(hit_oh);

endmodule

// File: rtl/ifetch_data_stage.sv
// Instruction-fetch data stage: tag compare, data-array read issue, miss
// reporting to the tag stage and L2, rollback squash and hit/miss counters.
module ifetch_data_stage
    import ifetch_data_stage_pkg::*;
(
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   ift_to_ifd_valid,
    input  logic [IFT_TO_IFD_BUS_WIDTH-1:0]        ift_to_ifd_bus,
    output logic                                   ifd_allowin,
    input  logic [L1_CACHE_NUM_WAYS-1:0]           icache_tag_valid,
    input  logic [L1_CACHE_NUM_WAYS*TAG_WIDTH-1:0] icache_tag,
    output logic                                   ifd_cache_miss,
    output logic                                   ifd_near_miss,
    output logic [NUM_WARP_PER_CORE_LOG-1:0]       ifd_cache_miss_warp_idx,
    output logic                                   icache_data_rd_en,
    output logic [L1_CACHE_NUM_SETS_LOG-1:0]       icache_data_rd_set,
    output logic [L1_CACHE_NUM_WAYS_LOG-1:0]       icache_data_rd_way,
    output logic                                   ifd_to_l2i_miss_en,
    output logic [ADDR_WIDTH-1:0]                  ifd_to_l2i_miss_addr,
    output logic [NUM_WARP_PER_CORE_LOG-1:0]       ifd_to_l2i_miss_warp_idx,
    input  logic                                   l2i_fill_en,
    input  logic [L1_CACHE_NUM_SETS_LOG-1:0]       l2i_fill_set,
    input  logic [TAG_WIDTH-1:0]                   l2i_fill_tag,
    input  logic                                   id_allowin,
    output logic                                   ifd_to_id_valid,
    output logic [IFD_TO_ID_BUS_WIDTH-1:0]         ifd_to_id_bus,
    input  logic                                   wb_rollback_en,
    input  logic [NUM_WARP_PER_CORE_LOG-1:0]       wb_rollback_warp_idx,
    output logic [31:0]                            ifd_hit_count,
    output logic [31:0]                            ifd_miss_count
);

    logic                                ifd_valid;
    logic [IFT_TO_IFD_BUS_WIDTH-1:0]     ifd_bus;
    logic                                ifd_counted;
    logic                                ifd_ready_go;

    logic [ADDR_WIDTH-1:0]               pc;
    logic [NUM_WARP_PER_CORE_LOG-1:0]    warp_idx;
    logic [L1_CACHE_NUM_SETS_LOG-1:0]    set_idx;
    logic [TAG_WIDTH-1:0]                tag;

    logic                                hit;
    logic [L1_CACHE_NUM_WAYS-1:0]        hit_oh;
    logic [L1_CACHE_NUM_WAYS_LOG-1:0]    hit_way;

    logic squash, live, fill_match;
    logic do_hit, do_near_miss, do_miss;
    logic hit_inc;

    assign pc       = ifd_bus[BUS_PC_LSB +: ADDR_WIDTH];
    assign warp_idx = ifd_bus[BUS_WARP_LSB +: NUM_WARP_PER_CORE_LOG];
    assign set_idx  = pc[CACHE_LINE_BYTE_WIDTH_LOG +: L1_CACHE_NUM_SETS_LOG];
    assign tag      = pc[ADDR_WIDTH-1 -: TAG_WIDTH];

    icache_tag_compare u_tag_compare (
        .tag_valid  (icache_tag_valid),
        .tags       (icache_tag),
        .lookup_tag (tag),
        .hit        (hit),
        .hit_oh     (hit_oh),
        .hit_way    (hit_way)
    );

    assign squash     = wb_rollback_en & (wb_rollback_warp_idx == warp_idx);
    assign live       = ifd_valid & ~squash;
    assign fill_match = l2i_fill_en & (l2i_fill_set == set_idx) & (l2i_fill_tag == tag);

    assign do_hit       = live & hit;
    assign do_near_miss = live & ~hit & fill_match;
    assign do_miss      = live & ~hit & ~fill_match;

    // Only a live hit can stall on decode; misses and squashed entries always retire.
    assign ifd_ready_go = 1'b1;
    assign ifd_allowin  = ~ifd_valid | (ifd_ready_go & id_allowin) | ~do_hit;

    assign hit_inc = do_hit & id_allowin & ~ifd_counted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifd_valid <= 1'b0;
        end else if (ifd_allowin) begin
            ifd_valid <= ift_to_ifd_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifd_bus <= '0;
        end else if (ifd_allowin & ift_to_ifd_valid) begin
            ifd_bus <= ift_to_ifd_bus;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifd_counted <= 1'b0;
        end else if (ifd_allowin) begin
            ifd_counted <= 1'b0;
        end else if (hit_inc) begin
            ifd_counted <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifd_hit_count  <= '0;
            ifd_miss_count <= '0;
        end else begin
            if (hit_inc) ifd_hit_count <= ifd_hit_count + 32'd1;
            if (do_miss) ifd_miss_count <= ifd_miss_count + 32'd1;
        end
    end

    assign icache_data_rd_en  = do_hit;
    assign icache_data_rd_set = do_hit ? set_idx : '0;
    assign icache_data_rd_way = do_hit ? hit_way : '0;

    assign ifd_to_id_valid = do_hit;
    assign ifd_to_id_bus   = ifd_bus;

    assign ifd_cache_miss          = do_miss;
    assign ifd_near_miss           = do_near_miss;
    assign ifd_cache_miss_warp_idx = (do_miss | do_near_miss) ? warp_idx : '0;

    assign ifd_to_l2i_miss_en       = do_miss;
    assign ifd_to_l2i_miss_addr     = do_miss ?
        {pc[ADDR_WIDTH-1:CACHE_LINE_BYTE_WIDTH_LOG], {CACHE_LINE_BYTE_WIDTH_LOG{1'b0}}} : '0;
    assign ifd_to_l2i_miss_warp_idx = do_miss ? warp_idx : '0;

    hit_onehot_chk: assert property (@(posedge clk) disable iff (!rst_n)
        ifd_valid |-> $onehot0(hit_oh))
        else $error("ifetch_data_stage: multiple icache ways hit");

endmodule
